// File: rtl/gnn_pkg.sv
// gnn_pkg: shared types and sizes for the GNN layer datapath blocks.
//   NODES/FEATS : shape of one ReLU batch (nodes x features per node).
//   IDX_W       : width of a node index.
//   wb_state_t  : relu_writeback FSM states.
package gnn_pkg;

    localparam int NODES = 4;
    localparam int FEATS = 4;
    localparam int IDX_W = $clog2(NODES);

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_WRITE,
        WB_DONE
    } wb_state_t;

endpackage

// File: rtl/relu_writeback_if.sv
// relu_writeback_if: node-feature memory write port (valid/grant handshake).
//   wr_en    : write request; wr_addr/wr_data valid while high.
//   wr_addr  : word address.
//   wr_data  : packed node word, feature 0 in the LSBs.
//   wr_grant : memory accepts the beat on a clock edge where wr_en & wr_grant.
// master = writer (relu_writeback), slave = memory.
interface relu_writeback_if
    import gnn_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_SIZE = 5
) ();

    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic [FEATS*DATA_SIZE-1:0]  wr_data;
    logic                        wr_grant;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_grant);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_grant);

endinterface

// File: rtl/relu_writeback.sv
// relu_writeback: snapshots a completed 4-node x 4-feature ReLU batch and
// writes it to the node-feature memory, one node word per accepted beat.
//   clk, rst_n       : clock (rising edge), async active-low reset.
//   relu_ready       : batch-valid level; each 0->1 transition is one batch.
//   in{f}_n{k}       : feature f of node k from relu_4n.
//   base_addr        : word address of node 0, sampled at capture.
//   wr               : memory write port (master side).
//   busy             : a batch is held or being written.
//   done             : one-cycle pulse after the last beat is accepted.
//   overrun          : sticky; a new batch arrived while still writing.
module relu_writeback
    import gnn_pkg::*;
#(
    parameter int DATA_SIZE = 5,
    parameter int ADDR_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        relu_ready,
    input  logic signed [DATA_SIZE-1:0] in0_n0, in1_n0, in2_n0, in3_n0,
    input  logic signed [DATA_SIZE-1:0] in0_n1, in1_n1, in2_n1, in3_n1,
    input  logic signed [DATA_SIZE-1:0] in0_n2, in1_n2, in2_n2, in3_n2,
    input  logic signed [DATA_SIZE-1:0] in0_n3, in1_n3, in2_n3, in3_n3,
    input  logic [ADDR_W-1:0]           base_addr,
    relu_writeback_if.master            wr,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun
);

    typedef logic [NODES-1:0][FEATS-1:0][DATA_SIZE-1:0] batch_t;

    batch_t            in_w, snap_q, snap_d;
    wb_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              ready_q;
    logic              overrun_q, overrun_d;
    logic              rise;

    // Node word is a plain bit concatenation, feature 0 lowest.
    assign in_w[0] = {in3_n0, in2_n0, in1_n0, in0_n0};
    assign in_w[1] = {in3_n1, in2_n1, in1_n1, in0_n1};
    assign in_w[2] = {in3_n2, in2_n2, in1_n2, in0_n2};
    assign in_w[3] = {in3_n3, in2_n3, in1_n3, in0_n3};

    assign rise = relu_ready & ~ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WB_IDLE;
            idx_q     <= '0;
            base_q    <= '0;
            snap_q    <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            snap_q    <= snap_d;
            ready_q   <= relu_ready;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        base_d    = base_q;
        snap_d    = snap_q;
        overrun_d = overrun_q;
        case (state_q)
            WB_IDLE: begin
                if (rise) begin
                    snap_d  = in_w;
                    base_d  = base_addr;
                    idx_d   = '0;
                    state_d = WB_WRITE;
                end
            end
            WB_WRITE: begin
                // A batch arriving mid-write is dropped; only flag it.
                if (rise) overrun_d = 1'b1;
                if (wr.wr_grant) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == IDX_W'(NODES - 1)) state_d = WB_DONE;
                end
            end
            WB_DONE: begin
                // Accepting a batch here gives the 5-cycle minimum period.
                if (rise) begin
                    snap_d  = in_w;
                    base_d  = base_addr;
                    idx_d   = '0;
                    state_d = WB_WRITE;
                end else begin
                    state_d = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // Outputs come straight from held state, so they stay stable while stalled.
    assign wr.wr_en   = (state_q == WB_WRITE);
    assign wr.wr_addr = base_q + ADDR_W'(idx_q);
    assign wr.wr_data = snap_q[idx_q];
    assign busy       = (state_q != WB_IDLE);
    assign done       = (state_q == WB_DONE);
    assign overrun    = overrun_q;

endmodule
